display_scan_driver: RTL

Producer side of the seven-segment path for the sequential multiplier's result display. Accepts a signed 8-bit product on a load strobe and converts it serially to sign + three BCD digits with an 8-step double-dabble. It then time-multiplexes four active-low anodes, driving active-low gfedcba segment patterns. The displayed value changes only when a conversion completes.

---
 rtl/display_pkg.sv | 20 ++
 rtl/bin8_to_bcd_seq.sv | 67 ++++++
 rtl/display_scan_driver.sv | 109 ++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared types and segment constants for the seven-segment result display.
// Segment patterns are active-low, bit order gfedcba.
package display_pkg;

  typedef enum logic [1:0] {StIdle, StConv, StLatch} bcd_state_e;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  localparam logic [6:0] SEG_DIGITS [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0011000
  };

  function automatic logic [6:0] digit_to_seg(input logic [3:0] d);
    if (d > 4'd9) return SEG_BLANK;
    return SEG_DIGITS[d];
  endfunction

endpackage

// File: rtl/bin8_to_bcd_seq.sv
// Serial 8-step double-dabble: 8-bit unsigned magnitude to three BCD digits.
// valid is high during the LATCH state, while hund/tens/ones hold the result.
module bin8_to_bcd_seq
  import display_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] mag,
  output logic       busy,
  output logic       valid,
  output logic [3:0] hund,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  bcd_state_e  state_q, state_d;
  logic [19:0] sr_q, sr_d;
  logic [2:0]  step_q, step_d;
  logic [19:0] adj;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  always_comb begin
    adj = {add3(sr_q[19:16]), add3(sr_q[15:12]), add3(sr_q[11:8]), sr_q[7:0]};
    state_d = state_q;
    sr_d    = sr_q;
    step_d  = step_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          sr_d    = {12'b0, mag};
          step_d  = 3'd0;
          state_d = StConv;
        end
      end
      StConv: begin
        sr_d   = {adj[18:0], 1'b0};
        step_d = step_q + 3'd1;
        if (step_q == 3'd7) state_d = StLatch;
      end
      StLatch: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      sr_q    <= '0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      step_q  <= step_d;
    end
  end

  assign busy  = (state_q != StIdle);
  assign valid = (state_q == StLatch);
  assign hund  = sr_q[19:16];
  assign tens  = sr_q[15:12];
  assign ones  = sr_q[11:8];

endmodule

// File: rtl/display_scan_driver.sv
// Converts a signed 8-bit product to sign + three BCD digits and scans them
// onto four active-low anodes with active-low gfedcba segments.
module display_scan_driver
  import display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] value,
  output logic       busy,
  output logic       done,
  output logic [3:0] an,
  output logic [6:0] seg
);

  localparam int unsigned PreW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic       conv_busy, conv_valid;
  logic [3:0] c_hund, c_tens, c_ones;
  logic [7:0] mag;

  logic            sign_pend_q, sign_pend_d;
  logic            disp_neg_q, disp_neg_d;
  logic [3:0]      disp_hund_q, disp_hund_d;
  logic [3:0]      disp_tens_q, disp_tens_d;
  logic [3:0]      disp_ones_q, disp_ones_d;
  logic            done_q, done_d;
  logic [PreW-1:0] pre_q, pre_d;
  logic [1:0]      idx_q, idx_d;
  logic [3:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;

  // -128 negates to 8'h80, which reads correctly as unsigned 128.
  assign mag = value[7] ? (~value + 8'd1) : value;

  bin8_to_bcd_seq u_conv (
    .clk   (clk),
    .rst   (rst),
    .start (load),
    .mag   (mag),
    .busy  (conv_busy),
    .valid (conv_valid),
    .hund  (c_hund),
    .tens  (c_tens),
    .ones  (c_ones)
  );

  always_comb begin
    sign_pend_d = (load && !conv_busy) ? value[7] : sign_pend_q;
    disp_neg_d  = conv_valid ? sign_pend_q : disp_neg_q;
    disp_hund_d = conv_valid ? c_hund : disp_hund_q;
    disp_tens_d = conv_valid ? c_tens : disp_tens_q;
    disp_ones_d = conv_valid ? c_ones : disp_ones_q;
    done_d      = conv_valid;

    pre_d = pre_q + PreW'(1);
    idx_d = idx_q;
    if (pre_q == PreW'(REFRESH_DIV - 1)) begin
      pre_d = '0;
      idx_d = idx_q + 2'd1;
    end

    // Outputs are built from the next index and digits so an/seg track idx_q exactly.
    an_d  = ~(4'b0001 << idx_d);
    seg_d = SEG_BLANK;
    unique case (idx_d)
      2'd0: seg_d = digit_to_seg(disp_ones_d);
      2'd1: seg_d = (disp_hund_d == 4'd0 && disp_tens_d == 4'd0) ? SEG_BLANK
                                                                  : digit_to_seg(disp_tens_d);
      2'd2: seg_d = (disp_hund_d == 4'd0) ? SEG_BLANK : digit_to_seg(disp_hund_d);
      2'd3: seg_d = disp_neg_d ? SEG_MINUS : SEG_BLANK;
      default: seg_d = SEG_BLANK;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign_pend_q <= 1'b0;
      disp_neg_q  <= 1'b0;
      disp_hund_q <= '0;
      disp_tens_q <= '0;
      disp_ones_q <= '0;
      done_q      <= 1'b0;
      pre_q       <= '0;
      idx_q       <= '0;
      an_q        <= 4'b1110;
      seg_q       <= 7'b1000000;
    end else begin
      sign_pend_q <= sign_pend_d;
      disp_neg_q  <= disp_neg_d;
      disp_hund_q <= disp_hund_d;
      disp_tens_q <= disp_tens_d;
      disp_ones_q <= disp_ones_d;
      done_q      <= done_d;
      pre_q       <= pre_d;
      idx_q       <= idx_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
    end
  end

  assign busy = conv_busy;
  assign done = done_q;
  assign an   = an_q;
  assign seg  = seg_q;

endmodule
